// File: rtl/rf_wr_sched.sv
// -----------------------------------------------------------------------------
// rf_wr_sched
//
// Write-port scheduler for an 8-entry register file. Two requesters share a
// single write port: requester 0 (ALU writeback) and requester 1 (memory load).
// Ties are broken round-robin on the last-granted requester. A single-cycle
// clr_req starts a clear sequence that writes zero to registers 0..7, one per
// cycle, while both requesters are held off.
//
// Handshake: a requester raises reqN_valid with reqN_sel/reqN_data stable and
// keeps them stable until it sees reqN_ready high in the same cycle; the
// transfer happens on the rising edge where valid and ready are both high.
// Ready is combinational from the valids, the round-robin pointer, the FSM
// state, clr_req and rst; it never depends on the data.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req0_valid/sel/data/ready     requester 0 (ALU writeback)
//   req1_valid/sel/data/ready     requester 1 (memory load)
//   clr_req                       request to zero all 8 registers
//   write/writeregsel/writedata   registered register-file write port
//   busy                          clear sequence in progress (registered)
//   err                           one-cycle pulse: clr_req while clearing
//   state_dbg                     current FSM state (0 = ARB, 1 = CLEAR)
// -----------------------------------------------------------------------------
module rf_wr_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [2:0]       req0_sel,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_sel,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             clr_req,
    output logic             write,
    output logic [2:0]       writeregsel,
    output logic [WIDTH-1:0] writedata,
    output logic             busy,
    output logic             err,
    output logic             state_dbg
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;      // next register to clear
    logic             ptr_q, ptr_d;      // last-granted requester
    logic             write_q, write_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic hs0, hs1;

    // Ready generation: only in ARB with no clear pending and not in reset.
    // On a tie the requester that was not granted last wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && state_q == ST_ARB && !clr_req) begin
            if (req0_valid && req1_valid) begin
                req0_ready = ptr_q;
                req1_ready = ~ptr_q;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign hs0 = req0_valid & req0_ready;
    assign hs1 = req1_valid & req1_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        write_d = 1'b0;
        sel_d   = sel_q;
        data_d  = data_q;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_ARB: begin
                if (clr_req) begin
                    // Register 0 is written on the entry edge, so the counter
                    // already points at register 1 once in CLEAR.
                    state_d = ST_CLEAR;
                    write_d = 1'b1;
                    sel_d   = 3'd0;
                    data_d  = '0;
                    busy_d  = 1'b1;
                    cnt_d   = 3'd1;
                end else if (hs0) begin
                    write_d = 1'b1;
                    sel_d   = req0_sel;
                    data_d  = req0_data;
                    ptr_d   = 1'b0;
                end else if (hs1) begin
                    write_d = 1'b1;
                    sel_d   = req1_sel;
                    data_d  = req1_data;
                    ptr_d   = 1'b1;
                end
            end
            ST_CLEAR: begin
                // A repeated clr_req is flagged but does not touch the count.
                write_d = 1'b1;
                sel_d   = cnt_q;
                data_d  = '0;
                busy_d  = 1'b1;
                err_d   = clr_req;
                cnt_d   = cnt_q + 3'd1;
                // Leave on the edge that loads register 7; cnt wraps to 0.
                if (cnt_q == 3'd7) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
            cnt_q   <= 3'd0;
            ptr_q   <= 1'b1;
            write_q <= 1'b0;
            sel_q   <= 3'd0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign write       = write_q;
    assign writeregsel = sel_q;
    assign writedata   = data_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_rf_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_rf_wr_sched
//
// Drives rf_wr_sched one cycle at a time through step(). step() applies the
// inputs shortly after a rising edge, samples every DUT output 1 ns later,
// computes what those outputs should be from a behavioural model (last-granted
// requester, number of clear writes still owed, and the pending write-port
// value), then advances the model alongside the clock edge. Each test task
// compares the sampled values against the model and against hand-derived
// constants.
// -----------------------------------------------------------------------------
module tb_rf_wr_sched;
    localparam int W = 16;
    localparam int VW = W + 9; // r0 r1 write sel[3] data busy err state

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, clr_req;
    logic [2:0]   req0_sel, req1_sel;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         write, busy, err, state_dbg;
    logic [2:0]   writeregsel;
    logic [W-1:0] writedata;

    int total = 0;
    int bad   = 0;

    rf_wr_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_data(req1_data), .req1_ready(req1_ready),
        .clr_req(clr_req),
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .busy(busy), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int           m_last = 1;   // last-granted requester
    int           m_left = 0;   // clear writes still owed after the first
    logic         m_write = 1'b0;
    logic [2:0]   m_sel = 3'd0;
    logic [W-1:0] m_data = '0;
    logic         m_busy = 1'b0;
    logic         m_err = 1'b0;

    // sampled and expected values of the last stepped cycle
    logic [VW-1:0] act_v, exp_v;
    logic a_r0, a_r1, a_write, a_busy, a_err, a_state;
    logic [2:0] a_sel;
    logic [W-1:0] a_data;

    task automatic step(input logic v0, input logic [2:0] s0, input logic [W-1:0] d0,
                        input logic v1, input logic [2:0] s1, input logic [W-1:0] d1,
                        input logic clr, input logic r);
        int g;
        req0_valid = v0; req0_sel = s0; req0_data = d0;
        req1_valid = v1; req1_sel = s1; req1_data = d1;
        clr_req = clr; rst = r;
        #1;
        g = -1;
        if (!r && m_left == 0 && !clr) begin
            if (v0 && v1) g = (m_last == 0) ? 1 : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        exp_v = {g == 0, g == 1, m_write, m_sel, m_data, m_busy, m_err, m_left > 0};
        a_r0 = req0_ready; a_r1 = req1_ready; a_write = write; a_sel = writeregsel;
        a_data = writedata; a_busy = busy; a_err = err; a_state = state_dbg;
        act_v = {a_r0, a_r1, a_write, a_sel, a_data, a_busy, a_err, a_state};
        if (r) begin
            m_last = 1; m_left = 0; m_write = 0; m_sel = 0; m_data = 0; m_busy = 0; m_err = 0;
        end else if (m_left > 0) begin
            m_write = 1; m_sel = 3'(8 - m_left); m_data = 0; m_busy = 1; m_err = clr;
            m_left--;
        end else if (clr) begin
            m_write = 1; m_sel = 0; m_data = 0; m_busy = 1; m_err = 0; m_left = 7;
        end else begin
            m_busy = 0; m_err = 0;
            if (g >= 0) begin
                m_write = 1;
                m_sel   = (g == 1) ? s1 : s0;
                m_data  = (g == 1) ? d1 : d0;
                m_last  = g;
            end else begin
                m_write = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 1, 0, 0, 0, 1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        // outputs now reflect the reset edge; valids high but rst still 1
        step(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 0, 1);
        total++;
        if (act_v !== {1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", act_v,
                     {1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_alternate();
        logic [W-1:0] d0, d1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d0 = W'($urandom); d1 = W'($urandom);
            step(1, 3'd2, d0, 1, 3'd5, d1, 0, 0);
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL alternate_model c%0d: got %h want %h", i, act_v, exp_v);
            end
            total++;
            if ({a_r0, a_r1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL alternate_grant c%0d: got %b%b want %s", i, a_r0, a_r1,
                         (i % 2 == 0) ? "10" : "01");
            end
            if (i > 0) begin
                total++;
                if ({a_write, a_sel} !== {1'b1, (i % 2 == 1) ? 3'd2 : 3'd5}) begin
                    bad++;
                    $display("FAIL alternate_write c%0d: got w=%b sel=%0d", i, a_write, a_sel);
                end
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        step(0, 3'd6, 16'h1234, 1, 3'd3, 16'hBEEF, 0, 0);
        total++;
        if ({a_r0, a_r1} !== 2'b01) begin
            bad++;
            $display("FAIL single_ready: got %b%b want 01", a_r0, a_r1);
        end
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0);
        total++;
        if ({a_write, a_sel, a_data} !== {1'b1, 3'd3, 16'hBEEF}) begin
            bad++;
            $display("FAIL single_write: got w=%b sel=%0d data=%h want w=1 sel=3 data=beef",
                     a_write, a_sel, a_data);
        end
        // idle cycle: write drops, address and data hold
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0);
        total++;
        if ({a_write, a_sel, a_data} !== {1'b0, 3'd3, 16'hBEEF}) begin
            bad++;
            $display("FAIL idle_hold: got w=%b sel=%0d data=%h want w=0 sel=3 data=beef",
                     a_write, a_sel, a_data);
        end
    endtask

    // clr_req at cycle 10, repeated at 13; both requesters valid throughout
    task automatic test_clear();
        logic [VW-1:0] want;
        logic clr;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            clr = (c == 10 || c == 13);
            step(1, 3'd2, W'(16'hA000 + c), 1, 3'd5, W'(16'hB000 + c), clr, 0);
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL clear_model c%0d: got %h want %h", c, act_v, exp_v);
            end
            if (c >= 10 && c <= 17) begin
                total++;
                if ({a_r0, a_r1} !== 2'b00) begin
                    bad++;
                    $display("FAIL clear_ready c%0d: got %b%b want 00", c, a_r0, a_r1);
                end
            end
            if (c >= 11 && c <= 18) begin
                want = {1'b0, 1'b0, 1'b1, 3'(c - 11), 16'h0000, 1'b1, c == 14, c <= 17};
                total++;
                if (act_v[VW-3:0] !== want[VW-3:0]) begin
                    bad++;
                    $display("FAIL clear_write c%0d: got %h want %h", c, act_v[VW-3:0], want[VW-3:0]);
                end
            end
            if (c == 18) begin
                total++;
                if ((a_r0 ^ a_r1) !== 1'b1) begin
                    bad++;
                    $display("FAIL clear_regrant: got %b%b want one-hot", a_r0, a_r1);
                end
            end
            if (c == 19) begin
                total++;
                if ({a_write, a_busy, a_err} !== 3'b100) begin
                    bad++;
                    $display("FAIL clear_after: got w=%b busy=%b err=%b want 1 0 0", a_write, a_busy, a_err);
                end
            end
        end
    endtask

    // clear started at cycle 10, reset at cycle 14
    task automatic test_rst_mid_clear();
        do_reset();
        // take one grant so the pointer is not at its reset value
        step(1, 3'd1, 16'h0101, 0, 3'd0, 16'h0, 0, 0);
        for (int c = 0; c <= 17; c++) begin
            step(c != 15, 3'd6, 16'h6666, 1, 3'd7, 16'h7777, c == 10, c == 14);
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL rstclr_model c%0d: got %h want %h", c, act_v, exp_v);
            end
            if (c == 15) begin
                total++;
                if ({a_write, a_busy, a_state} !== 3'b000) begin
                    bad++;
                    $display("FAIL rstclr_abort: got w=%b busy=%b st=%b want 0 0 0", a_write, a_busy, a_state);
                end
            end
        end
        // first tie after reset goes to requester 0
        step(1, 3'd6, 16'h6666, 1, 3'd7, 16'h7777, 0, 0);
        total++;
        if ({a_r0, a_r1} !== 2'b10) begin
            bad++;
            $display("FAIL rstclr_tie: got %b%b want 10", a_r0, a_r1);
        end
    endtask

    task automatic test_same_reg();
        do_reset();
        step(1, 3'd4, 16'hAAAA, 1, 3'd4, 16'hBBBB, 0, 0);
        step(0, 3'd0, 16'h0, 1, 3'd4, 16'hBBBB, 0, 0);
        total++;
        if ({a_write, a_sel, a_data} !== {1'b1, 3'd4, 16'hAAAA}) begin
            bad++;
            $display("FAIL same_reg_first: got w=%b sel=%0d data=%h want 1 4 aaaa", a_write, a_sel, a_data);
        end
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0);
        total++;
        if ({a_write, a_sel, a_data} !== {1'b1, 3'd4, 16'hBBBB}) begin
            bad++;
            $display("FAIL same_reg_second: got w=%b sel=%0d data=%h want 1 4 bbbb", a_write, a_sel, a_data);
        end
    endtask

    task automatic test_random();
        logic v0, v1;
        logic [2:0] s0, s1;
        logic [W-1:0] d0, d1;
        int errs;
        v0 = 0; v1 = 0; s0 = 0; s1 = 0; d0 = 0; d1 = 0;
        errs = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            // a pending request holds its payload until accepted
            if (!v0 || a_r0) begin
                v0 = ($urandom_range(0, 3) != 0); s0 = 3'($urandom); d0 = W'($urandom);
            end
            if (!v1 || a_r1) begin
                v1 = ($urandom_range(0, 3) != 0); s1 = 3'($urandom); d1 = W'($urandom);
            end
            step(v0, s0, d0, v1, s1, d1, $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0);
            total++;
            if (act_v !== exp_v) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random c%0d: got %h want %h", c, act_v, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0;
        req0_valid = 1'b0; req0_sel = 3'd0; req0_data = '0;
        req1_valid = 1'b0; req1_sel = 3'd0; req1_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_alternate();
        test_single();
        test_clear();
        test_rst_mid_clear();
        test_same_reg();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wr_sched.md
RF_WR_SCHED -- requirements
Module: rf_wr_sched

Interface
REQ-001 Parameter: WIDTH, default 16, register-file data width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 req0_sel  input  3  requester 0 destination register.
REQ-006 req0_data  input  WIDTH  requester 0 write data.
REQ-007 req0_ready  output  1  requester 0 accepted this cycle when req0_valid is also high.
REQ-008 req1_valid  input  1  requester 1 (memory load) has a write pending.
REQ-009 req1_sel  input  3  requester 1 destination register.
REQ-010 req1_data  input  WIDTH  requester 1 write data.
REQ-011 req1_ready  output  1  requester 1 accepted this cycle when req1_valid is also high.
REQ-012 clr_req  input  1  single-cycle request to zero all 8 registers.
REQ-013 write  output  1  register-file write enable, registered.
REQ-014 writeregsel  output  3  register-file write address, registered.
REQ-015 writedata  output  WIDTH  register-file write data, registered.
REQ-016 busy  output  1  clear sequence in progress, registered.
REQ-017 err  output  1  one-cycle pulse on protocol violation, registered.

Function
REQ-018 The FSM SHALL have two states, ARB and CLEAR, plus a 3-bit clear counter and a 1-bit round-robin pointer (last-granted requester).
REQ-019 In ARB with clr_req=0, the readys SHALL be combinational from valids and pointer: if exactly one valid is high, that requester is ready; if both are high, the requester not last granted is ready; at most one ready is high per cycle.
REQ-020 A handshake (valid & ready) at cycle N SHALL produce write=1, writeregsel=sel, writedata=data visible in cycle N+1 (latency 1) and SHALL set the pointer to the granted requester.
REQ-021 A cycle with no handshake and no clear activity SHALL produce write=0 in the following cycle, with writeregsel and writedata holding their previous values.
REQ-022 Both requesters targeting the same register SHALL NOT receive special treatment; the loser waits and is granted on a later cycle (its write lands last).
REQ-023 clr_req=1 in ARB at cycle N SHALL take priority over requests: both readys are 0 in cycle N, the state goes to CLEAR, and writes of 0 to registers 0,1,...,7 are visible in cycles N+1 through N+8, one per cycle, in ascending order.
REQ-024 In CLEAR, both readys SHALL be 0; the state SHALL return to ARB on the edge that loads register 7, so that grants are possible again from cycle N+8 and their writes become visible from N+9.
REQ-025 busy SHALL be 1 exactly in cycles N+1 through N+8 of a clear sequence.
REQ-026 clr_req=1 while in CLEAR SHALL be ignored for sequencing (the sequence is neither restarted nor extended) and SHALL pulse err=1 in the next cycle.
REQ-027 A requester whose valid is high and not granted SHALL keep priority eligibility; the pointer SHALL change only on a handshake.

Reset
REQ-028 rst=1 at an edge SHALL force state=ARB, counter=0, pointer=1 (so requester 0 wins the first tie), write=0, writeregsel=0, writedata=0, busy=0, err=0.
REQ-029 rst asserted mid-clear SHALL abort the sequence immediately; no further clear writes occur, and the remaining registers are left to the register file's own reset.
REQ-030 While rst=1, both readys SHALL be 0.

Verification
REQ-031 Post-reset: req0 and req1 both valid every cycle with sels 2 and 5 -> grants alternate 0,1,0,1; writes appear one cycle after each grant.
REQ-032 Only req1 valid (sel=3, data=16'hBEEF) -> req1_ready=1 the same cycle; next cycle write=1, writeregsel=3, writedata=16'hBEEF.
REQ-033 clr_req at cycle 10 with both valid -> readys 0 in cycles 10–17; writes of 0 to regs 0..7 in cycles 11–18; busy=1 in 11–18; first grant in 18, with its write in 19.
REQ-034 clr_req again at cycle 13 during a clear -> err=1 in cycle 14 only; the sequence still ends at cycle 18.
REQ-035 rst at cycle 14 during a clear -> from cycle 15 write=0, busy=0, state ARB; the next tie is granted to req0.
REQ-036 Both requesters target sel=4 with data A (req0) and B (req1) -> two consecutive writes to reg 4, A then B.
